operand2_encoder: RTL and testbench

Iterative encoder for the data-processing operand2 immediate format; it is the inverse of the operand2 shifter in the execute stage. Given a 32-bit constant, it searches for an (rot4, imm8) pair such that ROR(imm8, 2·rot4) equals the constant. In memory-offset mode it instead checks that the constant fits a 12-bit sign-extended offset. It sits beside the decode/execute path and serves the instruction loader and self-test logic that must build immediates in hardware.

---
 rtl/operand2_encoder_pkg.sv | 19 +
 rtl/operand2_encoder.sv | 97 +++++++++
 tb/tb_operand2_encoder.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/operand2_encoder_pkg.sv
// Shared definitions for the operand2 immediate encoder: FSM states,
// ISA field widths and the fixed 2-bit left rotation.
package operand2_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_t;

  localparam int ROT_W  = 4;
  localparam int IMM8_W = 8;
  localparam int OFF_W  = 12;

  function automatic logic [31:0] rol2(input logic [31:0] x);
    return {x[29:0], x[31:30]};
  endfunction

endpackage

// File: rtl/operand2_encoder.sv
// Iterative operand2 immediate encoder: finds the smallest rot4 such that
// ROR(imm8, 2*rot4) equals the input, or checks a 12-bit signed offset fit.
module operand2_encoder
  import operand2_encoder_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              in_ready,
  input  logic [31:0]       value,
  input  logic              mem_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              ok,
  output logic [OFF_W-1:0]  imm12,
  output logic              busy
);

  enc_state_t             r_state;
  enc_state_t             w_next;
  logic [31:0]            r_work;
  logic [ROT_W-1:0]       r_rot;
  logic                   r_mode;
  logic                   r_ok;
  logic [OFF_W-1:0]       r_imm12;

  logic                   w_fit8;
  logic                   w_fit12;
  logic                   w_last;

  assign w_fit8  = (r_work[31:IMM8_W] == '0);
  // Sign-extended 12-bit fit: bits 31..11 must all be copies of the sign.
  assign w_fit12 = (&r_work[31:OFF_W-1]) | ~(|r_work[31:OFF_W-1]);
  assign w_last  = (r_rot == {ROT_W{1'b1}});

  assign in_ready  = (r_state == IDLE);
  assign busy      = (r_state == SEARCH);
  assign out_valid = (r_state == DONE);
  assign ok        = r_ok;
  assign imm12     = r_imm12;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SEARCH;
      SEARCH:  if (r_mode || w_fit8 || w_last) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work  <= '0;
      r_rot   <= '0;
      r_mode  <= 1'b0;
      r_ok    <= 1'b0;
      r_imm12 <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_work <= value;
            r_rot  <= '0;
            r_mode <= mem_mode;
          end
        end
        SEARCH: begin
          if (r_mode) begin
            r_ok    <= w_fit12;
            r_imm12 <= w_fit12 ? r_work[OFF_W-1:0] : '0;
          end else if (w_fit8) begin
            r_ok    <= 1'b1;
            r_imm12 <= {r_rot, r_work[IMM8_W-1:0]};
          end else if (w_last) begin
            r_ok    <= 1'b0;
            r_imm12 <= '0;
          end else begin
            // Undo one step of the shifter's 2-bit right rotation per cycle.
            r_work <= rol2(r_work);
            r_rot  <= r_rot + ROT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_operand2_encoder.sv
// Scoreboard bench for operand2_encoder: expected {ok, imm12, latency}
// entries are queued at stimulus time and popped when out_valid rises.
module tb_operand2_encoder;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_ready;
  logic [31:0] value;
  logic        mem_mode;
  logic        out_valid;
  logic        out_ready;
  logic        ok;
  logic [11:0] imm12;
  logic        busy;

  typedef struct {
    logic        ok;
    logic [11:0] imm12;
    int          lat;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  operand2_encoder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_ready (in_ready),
    .value    (value),
    .mem_mode (mem_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ok       (ok),
    .imm12    (imm12),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: try every imm8 position by rotating the candidate back.
  function automatic exp_t model(input logic [31:0] v, input logic m);
    exp_t e;
    logic [31:0] r;
    e.ok = 1'b0; e.imm12 = 12'h000; e.lat = m ? 1 : 16;
    if (m) begin
      if ($signed(v) >= -2048 && $signed(v) <= 2047) begin
        e.ok = 1'b1; e.imm12 = v[11:0];
      end
      return e;
    end
    for (int k = 0; k < 16; k++) begin
      r = (k == 0) ? v : ((v << (2*k)) | (v >> (32 - 2*k)));
      if (r < 32'd256) begin
        e.ok = 1'b1; e.imm12 = {k[3:0], r[7:0]}; e.lat = k + 1;
        return e;
      end
    end
    return e;
  endfunction

  // One transaction; hold = cycles of backpressure in DONE, glitch = edge
  // index at which a stray start pulse is applied during SEARCH (-1 none).
  task automatic run_op(input logic [31:0] v, input logic m, input int hold,
                        input int glitch, input string name);
    exp_t e;
    int   edges;
    logic        s_ok;
    logic [11:0] s_imm;
    q.push_back(model(v, m));
    @(negedge clk);
    start = 1'b1; value = v; mem_mode = m; out_ready = (hold == 0);
    @(posedge clk); #1;
    start = 1'b0; value = $urandom; mem_mode = ~m;
    edges = 0;
    while (!out_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == glitch) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++; $display("FAIL %s busy: got %b want 1", name, busy);
        end
        start = 1'b1; value = 32'h000000FF; mem_mode = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    e = q.pop_front();
    checks++;
    if (edges !== e.lat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, edges, e.lat);
    end
    checks++;
    if (ok !== e.ok || imm12 !== e.imm12) begin
      errors++;
      $display("FAIL %s result: got ok=%b imm12=%h want ok=%b imm12=%h",
               name, ok, imm12, e.ok, e.imm12);
    end
    s_ok = ok; s_imm = imm12;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || ok !== s_ok || imm12 !== s_imm) begin
        errors++;
        $display("FAIL %s hold%0d: got v=%b rdy=%b ok=%b imm=%h want v=1 rdy=0 ok=%b imm=%h",
                 name, i, out_valid, in_ready, ok, imm12, s_ok, s_imm);
      end
    end
    if (hold > 0) begin
      @(negedge clk); out_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: got out_valid=%b in_ready=%b want 0 1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        ok !== 1'b0 || imm12 !== 12'h000) begin
      errors++;
      $display("FAIL %s: got rdy=%b busy=%b v=%b ok=%b imm=%h want 1 0 0 0 000",
               name, in_ready, busy, out_valid, ok, imm12);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; value = '0; mem_mode = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1 check_reset_outputs("post_reset_idle");
  endtask

  task automatic test_rotate();
    run_op(32'h000000FF, 1'b0, 0, -1, "rot0_ff");
    run_op(32'hFF000000, 1'b0, 0, -1, "rot4_ff");
    run_op(32'h00000104, 1'b0, 0, -1, "rot15_wrap");
    run_op(32'h00000101, 1'b0, 0, -1, "unencodable");
    run_op(32'h00000000, 1'b0, 0, -1, "zero");
    run_op(32'hF000000F, 1'b0, 0, -1, "wrap_f00f");
    run_op(32'h000003FC, 1'b0, 0, -1, "rot15_3fc");
  endtask

  task automatic test_mem();
    run_op(32'hFFFFF800, 1'b1, 0, -1, "mem_min");
    run_op(32'h00000800, 1'b1, 0, -1, "mem_over");
    run_op(32'h000007FF, 1'b1, 0, -1, "mem_max");
    run_op(32'hFFFFF7FF, 1'b1, 0, -1, "mem_under");
  endtask

  task automatic test_backpressure();
    run_op(32'h00AB0000, 1'b0, 5, -1, "bp_rot");
    run_op(32'h00000123, 1'b1, 5, -1, "bp_mem");
  endtask

  task automatic test_ignored_start();
    run_op(32'h00000104, 1'b0, 0, 3, "ign_start");
  endtask

  task automatic test_reset_mid_search();
    run_op(32'h0000002A, 1'b0, 0, -1, "pre_abort");
    @(negedge clk);
    start = 1'b1; value = 32'h00000101; mem_mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_abort");
    @(negedge clk); rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check_reset_outputs("abort_no_result");
    run_op(32'h3FC00000, 1'b0, 0, -1, "after_abort");
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    for (int i = 0; i < 12; i++) begin
      v = $urandom;
      if (i % 3 == 0) v = $urandom_range(255) << (2 * $urandom_range(15));
      run_op(v, i[0], 0, -1, "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_mem();
    test_backpressure();
    test_ignored_start();
    test_reset_mid_search();
    test_back_to_back();
    checks++;
    if (q.size() !== 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
